icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the datapath's fetch requests on the instruction half of `datapath_cache_if` and refills from main memory on the instruction half of `cache_control_if`. It sits between the pipelined datapath's IF stage and the memory controller/arbiter. One-word blocks; hits return in the same cycle, misses stall the fetch until memory responds.

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 100 ++++++++++
 tb/tb_icache.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and refill-side bundles of the instruction cache.
// The datapath is master on dcif and the cache is master on ccif.
`default_nettype none

interface datapath_cache_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;

   modport master (output imemREN, imemaddr, input  ihit, imemload);
   modport slave  (input  imemREN, imemaddr, output ihit, imemload);
endinterface

interface cache_control_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport master (output iREN, iaddr, input  iwait, iload);
   modport slave  (input  iREN, iaddr, output iwait, iload);
endinterface

`default_nettype wire

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache : direct-mapped, read-only, one-word-block instruction cache.
//          Zero-cycle hits; a miss stalls fetch until memory refills it.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache #(
   parameter int NSETS = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   datapath_cache_if.slave  dcif,
   cache_control_if.master  ccif
);
   localparam int IDX_W = $clog2(NSETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [0:0] {COMPARE = 1'b0, FETCH = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [31:0]        miss_addr;
   logic [NSETS-1:0]   valid;
   logic [TAG_W-1:0]   tags  [NSETS];
   logic [31:0]        words [NSETS];

   logic [TAG_W-1:0]   req_tag, miss_tag;
   logic [IDX_W-1:0]   req_idx, miss_idx;
   logic               hit, latch_miss, refill;
   logic               ihit_c, iren_c;
   logic [31:0]        load_c, iaddr_c;

   assign req_tag  = dcif.imemaddr[31:IDX_W+2];
   assign req_idx  = dcif.imemaddr[IDX_W+1:2];
   assign miss_tag = miss_addr[31:IDX_W+2];
   assign miss_idx = miss_addr[IDX_W+1:2];

   assign hit = dcif.imemREN & valid[req_idx] & (tags[req_idx] == req_tag);

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state     <= COMPARE;
         miss_addr <= '0;
         valid     <= '0;
      end else begin
         state <= state_nxt;
         if (latch_miss)
            miss_addr <= {dcif.imemaddr[31:2], 2'b00};
         if (refill)
            valid[miss_idx] <= 1'b1;
      end
   end

   // Tag/data arrays need no reset; the refill qualifier already excludes reset.
   always_ff @(posedge CLK) begin
      if (refill && !nRST) begin
         tags[miss_idx]  <= miss_tag;
         words[miss_idx] <= ccif.iload;
      end
   end

   always_comb begin
      state_nxt  = state;
      latch_miss = 1'b0;
      refill     = 1'b0;
      ihit_c     = 1'b0;
      load_c     = 32'h0;
      iren_c     = 1'b0;
      iaddr_c    = 32'h0;
      case (state)
         COMPARE: begin
            if (hit) begin
               ihit_c = 1'b1;
               load_c = words[req_idx];
            end else if (dcif.imemREN) begin
               latch_miss = 1'b1;
               state_nxt  = FETCH;
            end
         end
         FETCH: begin
            // Refill always targets miss_addr, whatever the datapath now requests.
            iren_c  = 1'b1;
            iaddr_c = miss_addr;
            if (!ccif.iwait) begin
               refill    = 1'b1;
               state_nxt = COMPARE;
            end
         end
         default: state_nxt = COMPARE;
      endcase
   end

   assign dcif.ihit     = ihit_c;
   assign dcif.imemload = load_c;
   assign ccif.iREN     = iren_c;
   assign ccif.iaddr    = iaddr_c;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// Directed bench for icache: expected fetch data is queued when a request is
// issued and popped when the cache raises ihit.
`default_nettype none

module tb_icache;
   logic CLK = 1'b0;
   logic nRST;

   datapath_cache_if dcif ();
   cache_control_if  ccif ();

   icache #(.NSETS(16)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .dcif (dcif.slave),
      .ccif (ccif.master)
   );

   always #5 CLK = ~CLK;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q [$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h40) return 32'h2001_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop the next expected word and compare it with the delivered load.
   task automatic sb_pop(input string tag);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk(tag, dcif.imemload, e);
      end
   endtask

   // One fetch; on a miss, memory answers after 'waits' busy cycles.
   task automatic fetch(input logic [31:0] addr, input int waits, input bit exp_hit);
      logic [31:0] blk;
      blk = {addr[31:2], 2'b00};
      sb_q.push_back(mem_data(blk));
      @(negedge CLK);
      dcif.imemREN  = 1'b1;
      dcif.imemaddr = addr;
      ccif.iwait    = 1'b1;
      #1;
      chk("req_ihit", {31'd0, dcif.ihit}, {31'd0, exp_hit});
      if (exp_hit) begin
         sb_pop("hit_data");
         chk("hit_iren", {31'd0, ccif.iREN}, 32'd0);
         @(posedge CLK);
         return;
      end
      @(posedge CLK);
      for (int i = 0; i < waits; i++) begin
         @(negedge CLK);
         #1;
         chk("wait_iren", {31'd0, ccif.iREN}, 32'd1);
         chk("wait_iaddr", ccif.iaddr, blk);
         @(posedge CLK);
      end
      @(negedge CLK);
      ccif.iwait = 1'b0;
      ccif.iload = mem_data(blk);
      #1;
      chk("fill_iren", {31'd0, ccif.iREN}, 32'd1);
      chk("fill_iaddr", ccif.iaddr, blk);
      @(posedge CLK);
      @(negedge CLK);
      ccif.iwait = 1'b1;
      ccif.iload = 32'hDEAD_BEEF;
      #1;
      chk("post_ihit", {31'd0, dcif.ihit}, 32'd1);
      sb_pop("miss_data");
      chk("post_iren", {31'd0, ccif.iREN}, 32'd0);
      @(posedge CLK);
   endtask

   initial begin
      nRST          = 1'b1;
      dcif.imemREN  = 1'b0;
      dcif.imemaddr = 32'h0;
      ccif.iwait    = 1'b1;
      ccif.iload    = 32'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("rst_ihit", {31'd0, dcif.ihit}, 32'd0);
      chk("rst_load", dcif.imemload, 32'd0);
      chk("rst_iren", {31'd0, ccif.iREN}, 32'd0);
      chk("rst_iaddr", ccif.iaddr, 32'd0);

      // First miss with three busy cycles, then a zero-latency refetch.
      fetch(32'h40, 3, 1'b0);
      fetch(32'h40, 0, 1'b1);

      // Fill every frame, then read them all back as consecutive hits.
      for (int a = 0; a < 64; a += 4) fetch(a, 0, 1'b0);
      for (int a = 0; a < 64; a += 4) fetch(a, 0, 1'b1);

      // Same index, different tag: each access evicts the other.
      fetch(32'h44, 1, 1'b0);
      fetch(32'h04, 0, 1'b0);
      fetch(32'h44, 0, 1'b0);

      // Redirect mid-fetch; 0x100 and 0x204 sit in different frames.
      @(negedge CLK);
      dcif.imemREN  = 1'b1;
      dcif.imemaddr = 32'h100;
      ccif.iwait    = 1'b1;
      #1;
      chk("redir_miss", {31'd0, dcif.ihit}, 32'd0);
      @(posedge CLK);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         dcif.imemaddr = 32'h204;
         #1;
         chk("redir_iaddr_hold", ccif.iaddr, 32'h100);
         chk("redir_ihit", {31'd0, dcif.ihit}, 32'd0);
         @(posedge CLK);
      end
      @(negedge CLK);
      ccif.iwait = 1'b0;
      ccif.iload = mem_data(32'h100);
      #1;
      chk("redir_fill_iaddr", ccif.iaddr, 32'h100);
      @(posedge CLK);
      @(negedge CLK);
      ccif.iwait = 1'b1;
      #1;
      chk("redir_new_miss", {31'd0, dcif.ihit}, 32'd0);
      @(posedge CLK);
      sb_q.push_back(mem_data(32'h204));
      @(negedge CLK);
      ccif.iwait = 1'b0;
      ccif.iload = mem_data(32'h204);
      #1;
      chk("redir2_iaddr", ccif.iaddr, 32'h204);
      @(posedge CLK);
      @(negedge CLK);
      ccif.iwait = 1'b1;
      #1;
      chk("redir2_ihit", {31'd0, dcif.ihit}, 32'd1);
      sb_pop("redir2_data");
      @(posedge CLK);
      fetch(32'h100, 0, 1'b1);
      fetch(32'h204, 0, 1'b1);

      // No request: nothing happens, even on a cached address.
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         dcif.imemREN  = 1'b0;
         dcif.imemaddr = (i == 0) ? 32'h100 : $urandom;
         #1;
         chk("idle_ihit", {31'd0, dcif.ihit}, 32'd0);
         chk("idle_iren", {31'd0, ccif.iREN}, 32'd0);
         chk("idle_load", dcif.imemload, 32'd0);
         @(posedge CLK);
      end

      // Byte offsets select the same word.
      fetch(32'h40, 2, 1'b0);
      fetch(32'h41, 0, 1'b1);
      fetch(32'h42, 0, 1'b1);
      fetch(32'h43, 0, 1'b1);

      // Reset during a refill whose data is presented at the reset edge.
      @(negedge CLK);
      dcif.imemREN  = 1'b1;
      dcif.imemaddr = 32'h300;
      ccif.iwait    = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("rstf_iren_before", {31'd0, ccif.iREN}, 32'd1);
      nRST       = 1'b1;
      ccif.iwait = 1'b0;
      ccif.iload = mem_data(32'h300);
      @(posedge CLK);
      @(negedge CLK);
      nRST         = 1'b0;
      ccif.iwait   = 1'b1;
      dcif.imemREN = 1'b0;
      #1;
      chk("rstf_iren_after", {31'd0, ccif.iREN}, 32'd0);
      chk("rstf_iaddr_after", ccif.iaddr, 32'd0);
      chk("rstf_ihit_after", {31'd0, dcif.ihit}, 32'd0);
      @(posedge CLK);
      fetch(32'h40, 0, 1'b0);
      fetch(32'h300, 0, 1'b0);
      fetch(32'h40, 0, 1'b0);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
